// File: rtl/e_core_ctrl_pkg.sv
// Shared lifecycle-state definitions for the e_core_ss control plane.
package e_core_ctrl_pkg;

    localparam int unsigned LC_STATE_W = 3;

    typedef enum logic [LC_STATE_W-1:0] {
        LC_IDLE  = 3'd0,
        LC_HOLD  = 3'd1,
        LC_RUN   = 3'd2,
        LC_SLEEP = 3'd3,
        LC_HALT  = 3'd4,
        LC_FAULT = 3'd5
    } lc_state_e;

    // True for states in which the core is out of reset.
    function automatic logic lc_core_released(input lc_state_e s);
        return (s == LC_RUN) || (s == LC_SLEEP) || (s == LC_HALT) || (s == LC_FAULT);
    endfunction

endpackage

// File: rtl/e_core_lifecycle_ctrl_if.sv
// Control/status bundle between the lifecycle controller and e_core_ss.
interface e_core_lifecycle_ctrl_if;

    logic core_resetn_o;
    logic core_clk_en_o;
    logic core_irq_o;
    logic core_halted_i;
    logic core_fault_i;
    logic core_wfi_i;

    // Controller side.
    modport master (
        output core_resetn_o,
        output core_clk_en_o,
        output core_irq_o,
        input  core_halted_i,
        input  core_fault_i,
        input  core_wfi_i
    );

    // Core side.
    modport slave (
        input  core_resetn_o,
        input  core_clk_en_o,
        input  core_irq_o,
        output core_halted_i,
        output core_fault_i,
        output core_wfi_i
    );

endinterface

// File: rtl/e_core_wfi_filter.sv
// Consecutive-cycle counter: expired_o is high on the DELAY-th consecutive
// cycle with inc_i high (and every later one), so the consumer can act on
// the same edge that completes the run.
module e_core_wfi_filter #(
    parameter int unsigned DELAY = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned     CNT_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count up to DELAY-1 and hold there; any gap or clear restarts the run.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !inc_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = !clear_i && inc_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/e_core_lifecycle_ctrl.sv
// Lifecycle controller for e_core_ss: reset sequencing, WFI clock gating,
// interrupt wake-up and fault/halt trapping.
module e_core_lifecycle_ctrl
    import e_core_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned WFI_GATE_DELAY  = 4,
    parameter int unsigned FAULT_CNT_W     = 8,
    parameter bit          AUTO_RESTART    = 1'b0
) (
    input  logic                   io_aclk,
    input  logic                   io_aresetn,
    input  logic                   start_i,
    input  logic                   stop_req_i,
    input  logic                   irq_i,
    e_core_lifecycle_ctrl_if.master core_if,
    output logic [LC_STATE_W-1:0]  state_o,
    output logic [FAULT_CNT_W-1:0] fault_cnt_o,
    output logic                   busy_o
);

    localparam int unsigned            HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [FAULT_CNT_W-1:0] FCNT_MAX  = '1;

    lc_state_e              state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   core_resetn_q, core_resetn_d;
    logic                   core_clk_en_q, core_clk_en_d;
    logic                   core_irq_q, core_irq_d;
    logic                   busy_q, busy_d;
    logic                   wfi_clear;
    logic                   wfi_expired;

    assign wfi_clear = (state_q != LC_RUN);

    e_core_wfi_filter #(
        .DELAY (WFI_GATE_DELAY)
    ) u_wfi_filter (
        .clk_i     (io_aclk),
        .rstn_i    (io_aresetn),
        .clear_i   (wfi_clear),
        .inc_i     (core_if.core_wfi_i),
        .expired_o (wfi_expired)
    );

    // Next-state, counters and next-cycle output values.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fcnt_d  = fcnt_q;

        unique case (state_q)
            LC_IDLE: begin
                if (start_i) begin
                    state_d = LC_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            LC_HOLD: begin
                if (hold_q == '0) begin
                    state_d = LC_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            LC_RUN: begin
                if (stop_req_i) begin
                    state_d = LC_IDLE;
                end else if (core_if.core_fault_i) begin
                    state_d = LC_FAULT;
                    if (fcnt_q != FCNT_MAX) begin
                        fcnt_d = fcnt_q + FAULT_CNT_W'(1);
                    end
                end else if (core_if.core_halted_i) begin
                    state_d = LC_HALT;
                end else if (wfi_expired) begin
                    state_d = LC_SLEEP;
                end
            end
            LC_SLEEP: begin
                if (stop_req_i) begin
                    state_d = LC_IDLE;
                end else if (irq_i) begin
                    state_d = LC_RUN;
                end
            end
            LC_HALT: begin
                if (stop_req_i) begin
                    state_d = LC_IDLE;
                end else if (!core_if.core_halted_i) begin
                    state_d = LC_RUN;
                end
            end
            LC_FAULT: begin
                if (stop_req_i) begin
                    state_d = LC_IDLE;
                end else if (AUTO_RESTART || start_i) begin
                    state_d = LC_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            default: begin
                state_d = LC_IDLE;
            end
        endcase

        if (state_d == LC_IDLE) begin
            hold_d = '0;
        end

        // Outputs follow the state being entered so they line up with state_o.
        core_resetn_d = lc_core_released(state_d);
        core_clk_en_d = (state_d != LC_SLEEP);
        core_irq_d    = irq_i && lc_core_released(state_d);
        busy_d        = (state_d == LC_HOLD);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge io_aclk) begin
        if (!io_aresetn) begin
            state_q       <= LC_IDLE;
            hold_q        <= '0;
            fcnt_q        <= '0;
            core_resetn_q <= 1'b0;
            core_clk_en_q <= 1'b1;
            core_irq_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            fcnt_q        <= fcnt_d;
            core_resetn_q <= core_resetn_d;
            core_clk_en_q <= core_clk_en_d;
            core_irq_q    <= core_irq_d;
            busy_q        <= busy_d;
        end
    end

    assign core_if.core_resetn_o = core_resetn_q;
    assign core_if.core_clk_en_o = core_clk_en_q;
    assign core_if.core_irq_o    = core_irq_q;
    assign state_o               = state_q;
    assign fault_cnt_o           = fcnt_q;
    assign busy_o                = busy_q;

endmodule

// File: tb/tb_e_core_lifecycle_ctrl.sv
// Bench for e_core_lifecycle_ctrl: two instances (default parameters and a
// short-hold / 2-bit-counter / auto-restart variant) share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_e_core_lifecycle_ctrl;
    import e_core_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rstn, start, stop, irq, halted, fault, wfi;

    logic [2:0] state0, state1;
    logic [7:0] fcnt0;
    logic [1:0] fcnt1;
    logic       busy0, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    e_core_lifecycle_ctrl_if cif0 ();
    e_core_lifecycle_ctrl_if cif1 ();

    assign cif0.core_halted_i = halted;
    assign cif0.core_fault_i  = fault;
    assign cif0.core_wfi_i    = wfi;
    assign cif1.core_halted_i = halted;
    assign cif1.core_fault_i  = fault;
    assign cif1.core_wfi_i    = wfi;

    e_core_lifecycle_ctrl dut0 (
        .io_aclk     (clk),
        .io_aresetn  (rstn),
        .start_i     (start),
        .stop_req_i  (stop),
        .irq_i       (irq),
        .core_if     (cif0),
        .state_o     (state0),
        .fault_cnt_o (fcnt0),
        .busy_o      (busy0)
    );

    e_core_lifecycle_ctrl #(
        .RST_HOLD_CYCLES (3),
        .WFI_GATE_DELAY  (2),
        .FAULT_CNT_W     (2),
        .AUTO_RESTART    (1'b1)
    ) dut1 (
        .io_aclk     (clk),
        .io_aresetn  (rstn),
        .start_i     (start),
        .stop_req_i  (stop),
        .irq_i       (irq),
        .core_if     (cif1),
        .state_o     (state1),
        .fault_cnt_o (fcnt1),
        .busy_o      (busy1)
    );

    // Per-instance parameters as the model sees them.
    function automatic int p_hold(input int k);
        return (k == 0) ? 16 : 3;
    endfunction
    function automatic int p_wfi(input int k);
        return (k == 0) ? 4 : 2;
    endfunction
    function automatic int p_fmax(input int k);
        return (k == 0) ? 255 : 3;
    endfunction
    function automatic bit p_auto(input int k);
        return (k != 0);
    endfunction

    // Model: current state, HOLD cycles still to spend, length of the current
    // wfi streak inside RUN, faults seen, and the expected irq output.
    lc_state_e m_st[2];
    int        m_hold[2];
    int        m_streak[2];
    int        m_fcnt[2];
    bit        m_irq[2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            lc_state_e nx;
            if (!rstn) begin
                m_st[k] = LC_IDLE; m_hold[k] = 0; m_streak[k] = 0;
                m_fcnt[k] = 0; m_irq[k] = 1'b0;
            end else begin
                nx = m_st[k];
                if (m_st[k] == LC_RUN) m_streak[k] = wfi ? m_streak[k] + 1 : 0;
                else m_streak[k] = 0;
                case (m_st[k])
                    LC_IDLE: if (start) begin nx = LC_HOLD; m_hold[k] = p_hold(k); end
                    LC_HOLD: begin
                        m_hold[k] = m_hold[k] - 1;
                        if (m_hold[k] == 0) nx = LC_RUN;
                    end
                    LC_RUN: begin
                        if (stop) nx = LC_IDLE;
                        else if (fault) begin
                            nx = LC_FAULT;
                            if (m_fcnt[k] < p_fmax(k)) m_fcnt[k] = m_fcnt[k] + 1;
                        end
                        else if (halted) nx = LC_HALT;
                        else if (m_streak[k] >= p_wfi(k)) nx = LC_SLEEP;
                    end
                    LC_SLEEP: if (stop) nx = LC_IDLE; else if (irq) nx = LC_RUN;
                    LC_HALT:  if (stop) nx = LC_IDLE; else if (!halted) nx = LC_RUN;
                    LC_FAULT: begin
                        if (stop) nx = LC_IDLE;
                        else if (p_auto(k) || start) begin nx = LC_HOLD; m_hold[k] = p_hold(k); end
                    end
                    default: nx = LC_IDLE;
                endcase
                if (nx == LC_IDLE) m_hold[k] = 0;
                m_irq[k] = irq && !(nx == LC_IDLE || nx == LC_HOLD);
                m_st[k]  = nx;
            end
        end
    endtask

    task automatic check_inst(input int k, input logic [2:0] st, input logic rn,
                              input logic ce, input logic iq, input int fc, input logic bz);
        bit up;
        up = !(m_st[k] == LC_IDLE || m_st[k] == LC_HOLD);
        chk($sformatf("i%0d_state", k),  int'(st), int'(m_st[k]));
        chk($sformatf("i%0d_resetn", k), int'(rn), int'(up));
        chk($sformatf("i%0d_clk_en", k), int'(ce), int'(m_st[k] != LC_SLEEP));
        chk($sformatf("i%0d_irq", k),    int'(iq), int'(m_irq[k]));
        chk($sformatf("i%0d_fcnt", k),   fc, m_fcnt[k]);
        chk($sformatf("i%0d_busy", k),   int'(bz), int'(m_st[k] == LC_HOLD));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_inst(0, state0, cif0.core_resetn_o, cif0.core_clk_en_o, cif0.core_irq_o, int'(fcnt0), busy0);
        check_inst(1, state1, cif1.core_resetn_o, cif1.core_clk_en_o, cif1.core_irq_o, int'(fcnt1), busy1);
    endtask

    // Start pulse on instance 0: 16 cycles busy with core in reset, then RUN.
    task automatic hold_seq(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_first"}, int'(busy0), 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk({tag, "_busy"}, int'(busy0), 1);
            chk({tag, "_held"}, int'(cif0.core_resetn_o), 0);
        end
        tick();
        chk({tag, "_released"}, int'(cif0.core_resetn_o), 1);
        chk({tag, "_run"}, int'(state0), 2);
        chk({tag, "_busy_off"}, int'(busy0), 0);
    endtask

    // Drive instance 1 into RUN, bounded.
    task automatic wait_run1();
        int budget;
        budget = 100;
        while (m_st[1] != LC_RUN && budget > 0) begin
            start = (m_st[1] == LC_IDLE);
            tick();
            budget--;
        end
        start = 1'b0;
        chk("wait_run1", int'(state1), 2);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; irq = 1'b0;
        halted = 1'b0; fault = 1'b0; wfi = 1'b0;
        tick();
        tick();
        chk("rst_state",  int'(state0), 0);
        chk("rst_resetn", int'(cif0.core_resetn_o), 0);
        chk("rst_clk_en", int'(cif0.core_clk_en_o), 1);
        chk("rst_irq",    int'(cif0.core_irq_o), 0);
        chk("rst_fcnt",   int'(fcnt0), 0);
        chk("rst_busy",   int'(busy0), 0);
        rstn = 1'b1;
        tick();

        hold_seq("start");

        // Short wfi burst must not gate; a 4-cycle run gates on its 4th edge.
        wfi = 1'b1;
        repeat (3) tick();
        wfi = 1'b0;
        tick();
        chk("wfi_short", int'(cif0.core_clk_en_o), 1);
        wfi = 1'b1;
        repeat (3) tick();
        chk("wfi_pre", int'(cif0.core_clk_en_o), 1);
        tick();
        chk("wfi_gate",  int'(cif0.core_clk_en_o), 0);
        chk("wfi_sleep", int'(state0), 3);

        // Interrupt wakes the core with clock and irq together.
        wfi = 1'b0;
        irq = 1'b1;
        tick();
        irq = 1'b0;
        chk("wake_clk_en", int'(cif0.core_clk_en_o), 1);
        chk("wake_irq",    int'(cif0.core_irq_o), 1);
        chk("wake_state",  int'(state0), 2);
        tick();
        chk("wake_irq_off", int'(cif0.core_irq_o), 0);

        // Three faults, each restarted by start with a full hold.
        for (int i = 0; i < 3; i++) begin
            fault = 1'b1;
            tick();
            fault = 1'b0;
            chk("fault_state",  int'(state0), 5);
            chk("fault_cnt",    int'(fcnt0), i + 1);
            chk("fault_resetn", int'(cif0.core_resetn_o), 1);
            hold_seq("restart");
        end
        chk("fault_cnt3", int'(fcnt0), 3);

        // Stop and fault together: stop wins, no count.
        stop = 1'b1;
        fault = 1'b1;
        tick();
        stop = 1'b0;
        fault = 1'b0;
        chk("stopfault_state",  int'(state0), 0);
        chk("stopfault_resetn", int'(cif0.core_resetn_o), 0);
        chk("stopfault_fcnt",   int'(fcnt0), 3);

        // Reset in the middle of HOLD, then a fresh full hold.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rstn = 1'b0;
        tick();
        chk("midhold_state",  int'(state0), 0);
        chk("midhold_resetn", int'(cif0.core_resetn_o), 0);
        chk("midhold_clk_en", int'(cif0.core_clk_en_o), 1);
        chk("midhold_irq",    int'(cif0.core_irq_o), 0);
        chk("midhold_fcnt",   int'(fcnt0), 0);
        chk("midhold_busy",   int'(busy0), 0);
        rstn = 1'b1;
        tick();
        hold_seq("rehold");

        // Reset while asleep re-enables the clock.
        wfi = 1'b1;
        repeat (4) tick();
        wfi = 1'b0;
        chk("sleep2_state", int'(state0), 3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midsleep_clk_en", int'(cif0.core_clk_en_o), 1);
        chk("midsleep_state",  int'(state0), 0);

        // Five faults on the 2-bit, auto-restarting instance saturate at 3.
        for (int n = 0; n < 5; n++) begin
            wait_run1();
            fault = 1'b1;
            tick();
            fault = 1'b0;
        end
        chk("sat_fcnt", int'(fcnt1), 3);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            rstn   = ($urandom_range(0, 499) != 0);
            start  = ($urandom_range(0, 7) == 0);
            stop   = ($urandom_range(0, 39) == 0);
            fault  = ($urandom_range(0, 29) == 0);
            irq    = ($urandom_range(0, 9) == 0);
            halted = halted ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) == 0);
            wfi    = wfi ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
